// File: rtl/pong_pkg.sv
// Shared pong types and helpers: field width derivation, direction encoding and
// flattened-bus slice offsets. Used by the paddle and ball/collision blocks.
package pong_pkg;

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  function automatic int y_width(input int height);
    return (height <= 2) ? 1 : $clog2(height);
  endfunction

  // Low bit of element idx in a flattened bus of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // Per-channel control pair: [1]=up (+y), [0]=down (-y); both or neither is no move.
  function automatic dir_t decode_dir(input logic [1:0] ctl);
    case (ctl)
      2'b10:   return DIR_UP;
      2'b01:   return DIR_DOWN;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle channel: centre-row register with saturating moves on frame ticks
// and hold-to-accelerate step sizing.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int HEIGHT        = 16,
  parameter int PADDLE_HEIGHT = 5,
  parameter int HOLD_TICKS    = 4,
  parameter int MAX_STEP      = 3,
  parameter int Y_W           = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           freeze,
  input  logic           centre_req,
  input  logic [1:0]     ctl,
  output logic [Y_W-1:0] y,
  output logic           at_min,
  output logic           at_max,
  output logic           moving
);

  localparam int HALF = (PADDLE_HEIGHT - 1) / 2;
  localparam int S_W  = $clog2(MAX_STEP + 1);
  localparam int H_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [Y_W:0]   Y_MIN     = (Y_W+1)'(HALF);
  localparam logic [Y_W:0]   Y_MAX     = (Y_W+1)'(HEIGHT - 1 - HALF);
  localparam logic [Y_W:0]   Y_CTR     = (Y_W+1)'(HEIGHT / 2);
  localparam logic [S_W-1:0] STEP_ONE  = S_W'(1);
  localparam logic [S_W-1:0] STEP_MAX  = S_W'(MAX_STEP);
  localparam logic [H_W-1:0] HOLD_LAST = H_W'(HOLD_TICKS - 1);

  logic [Y_W-1:0] y_q;
  logic [S_W-1:0] step_q;
  logic [H_W-1:0] hold_q;
  dir_t           last_q;
  logic           moving_q;

  dir_t           dir;
  logic           cont;
  logic [S_W-1:0] step_nx;
  logic [H_W-1:0] hold_nx;
  logic [Y_W:0]   y_ext;
  logic [Y_W:0]   step_ext;
  logic [Y_W:0]   y_move;
  logic [Y_W-1:0] y_nx;

  // A continued press (same direction as the previous tick) counts toward the
  // next step increment; the move on the incrementing tick already uses the new step.
  always_comb begin
    dir     = decode_dir(ctl);
    cont    = (dir != DIR_NONE) && (dir == last_q);
    step_nx = STEP_ONE;
    hold_nx = '0;
    if (cont) begin
      if (hold_q == HOLD_LAST) begin
        hold_nx = '0;
        step_nx = (step_q == STEP_MAX) ? step_q : step_q + STEP_ONE;
      end else begin
        hold_nx = hold_q + 1'b1;
        step_nx = step_q;
      end
    end
    y_ext    = {1'b0, y_q};
    step_ext = (Y_W+1)'(step_nx);
    y_move   = y_ext;
    if (dir == DIR_UP) begin
      y_move = ((y_ext + step_ext) > Y_MAX) ? Y_MAX : (y_ext + step_ext);
    end else if (dir == DIR_DOWN) begin
      y_move = ((y_ext - Y_MIN) >= step_ext) ? (y_ext - step_ext) : Y_MIN;
    end
    y_nx = y_move[Y_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= Y_CTR[Y_W-1:0];
      step_q   <= STEP_ONE;
      hold_q   <= '0;
      last_q   <= DIR_NONE;
      moving_q <= 1'b0;
    end else if (centre_req) begin
      y_q      <= Y_CTR[Y_W-1:0];
      step_q   <= STEP_ONE;
      hold_q   <= '0;
      last_q   <= DIR_NONE;
      moving_q <= 1'b0;
    end else if (freeze) begin
      moving_q <= 1'b0;
    end else if (tick) begin
      y_q      <= y_nx;
      step_q   <= step_nx;
      hold_q   <= hold_nx;
      last_q   <= dir;
      moving_q <= (y_nx != y_q);
    end else begin
      moving_q <= 1'b0;
    end
  end

  assign y      = y_q;
  assign moving = moving_q;
  assign at_min = ({1'b0, y_q} == Y_MIN);
  assign at_max = ({1'b0, y_q} == Y_MAX);

endmodule

// File: rtl/paddle_ctrl_multi.sv
// N-channel paddle controller: slices the flattened control/position buses and
// fans them out to one paddle_axis per paddle.
module paddle_ctrl_multi
  import pong_pkg::*;
#(
  parameter int N_PADDLES     = 2,
  parameter int HEIGHT        = 16,
  parameter int PADDLE_HEIGHT = 5,
  parameter int HOLD_TICKS    = 4,
  parameter int MAX_STEP      = 3,
  localparam int Y_W          = y_width(HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     freeze,
  input  logic [2*N_PADDLES-1:0]   controls,
  input  logic [N_PADDLES-1:0]     centre_req,
  output logic [N_PADDLES*Y_W-1:0] paddle_y,
  output logic [N_PADDLES-1:0]     at_min,
  output logic [N_PADDLES-1:0]     at_max,
  output logic [N_PADDLES-1:0]     moving
);

  if (PADDLE_HEIGHT % 2 != 1) begin : g_chk_odd
    $error("PADDLE_HEIGHT must be odd");
  end
  if (PADDLE_HEIGHT > HEIGHT) begin : g_chk_fit
    $error("PADDLE_HEIGHT must not exceed HEIGHT");
  end
  if (MAX_STEP < 1) begin : g_chk_step
    $error("MAX_STEP must be at least 1");
  end
  if (HOLD_TICKS < 1) begin : g_chk_hold
    $error("HOLD_TICKS must be at least 1");
  end

  for (genvar i = 0; i < N_PADDLES; i++) begin : g_ch
    paddle_axis #(
      .HEIGHT        (HEIGHT),
      .PADDLE_HEIGHT (PADDLE_HEIGHT),
      .HOLD_TICKS    (HOLD_TICKS),
      .MAX_STEP      (MAX_STEP),
      .Y_W           (Y_W)
    ) u_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .freeze     (freeze),
      .centre_req (centre_req[i]),
      .ctl        (controls[slice_lo(i, 2) +: 2]),
      .y          (paddle_y[slice_lo(i, Y_W) +: Y_W]),
      .at_min     (at_min[i]),
      .at_max     (at_max[i]),
      .moving     (moving[i])
    );
  end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Scoreboard bench for paddle_ctrl_multi: a 64-row instance and a 16-row instance,
// directed tick sequences with hand-computed paddle positions.
module tb_paddle_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tk64 = 1'b0, tk16 = 1'b0, fr64 = 1'b0, prb = 1'b0;
  logic [3:0]  ctl64 = '0, ctl16 = '0;
  logic [1:0]  cr64 = '0;
  logic [11:0] py64;
  logic [7:0]  py16;
  logic [1:0]  mn64, mx64, mv64, mn16, mx16, mv16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is16;
    int         y0;
    int         y1;
    logic [1:0] mv;
    logic [1:0] mn;
    logic [1:0] mx;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  paddle_ctrl_multi #(
    .N_PADDLES(2), .HEIGHT(64), .PADDLE_HEIGHT(5), .HOLD_TICKS(4), .MAX_STEP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tk64), .freeze(fr64), .controls(ctl64),
    .centre_req(cr64), .paddle_y(py64), .at_min(mn64), .at_max(mx64), .moving(mv64)
  );

  paddle_ctrl_multi #(
    .N_PADDLES(2), .HEIGHT(16), .PADDLE_HEIGHT(5), .HOLD_TICKS(4), .MAX_STEP(3)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .tick(tk16), .freeze(1'b0), .controls(ctl16),
    .centre_req(2'b00), .paddle_y(py16), .at_min(mn16), .at_max(mx16), .moving(mv16)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: the cycle after a tick (or a probe) the DUT presents a new result.
  initial begin
    exp_t e;
    bit   pres;
    forever begin
      @(posedge clk);
      pres = tk64 | tk16 | prb;
      if (pres) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got output with no expectation");
        end else begin
          e = exp_q.pop_front();
          if (e.is16) begin
            chk("h16_y0", int'(py16[3:0]), e.y0);
            chk("h16_y1", int'(py16[7:4]), e.y1);
            chk("h16_moving", int'(mv16), int'(e.mv));
            chk("h16_at_min", int'(mn16), int'(e.mn));
            chk("h16_at_max", int'(mx16), int'(e.mx));
          end else begin
            chk("h64_y0", int'(py64[5:0]), e.y0);
            chk("h64_y1", int'(py64[11:6]), e.y1);
            chk("h64_moving", int'(mv64), int'(e.mv));
            chk("h64_at_min", int'(mn64), int'(e.mn));
            chk("h64_at_max", int'(mx64), int'(e.mx));
          end
        end
      end
    end
  end

  task automatic drive(input bit d16, input logic [3:0] c, input bit tk,
                       input logic [1:0] cr, input bit fz, input int y0, input int y1,
                       input logic [1:0] mv, input logic [1:0] mn, input logic [1:0] mx);
    exp_t e;
    e.is16 = d16; e.y0 = y0; e.y1 = y1; e.mv = mv; e.mn = mn; e.mx = mx;
    exp_q.push_back(e);
    @(negedge clk);
    if (d16) begin
      ctl16 = c; tk16 = tk;
    end else begin
      ctl64 = c; tk64 = tk; cr64 = cr; fr64 = fz;
    end
    prb = !tk;
    @(negedge clk);
    tk64 = 1'b0; tk16 = 1'b0; cr64 = 2'b00; prb = 1'b0;
  endtask

  task automatic t64(input logic [3:0] c, input int y0, input int y1, input logic [1:0] mv);
    drive(1'b0, c, 1'b1, 2'b00, fr64, y0, y1, mv, 2'b00, 2'b00);
  endtask

  task automatic p64(input int y0, input int y1);
    drive(1'b0, ctl64, 1'b0, 2'b00, fr64, y0, y1, 2'b00, 2'b00, 2'b00);
  endtask

  int up_seq[10] = '{33, 34, 35, 36, 38, 40, 42, 44, 47, 50};
  int dn16[5]    = '{7, 6, 5, 4, 2};
  int up16[5]    = '{9, 10, 11, 12, 13};

  initial begin
    // Reset state, sampled while reset is held and after release.
    p64(32, 32);
    drive(1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 8, 8, 2'b00, 2'b00, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    p64(32, 32);

    // Accelerate p0 to 44 (step 2), then a short async reset pulse between edges.
    for (int i = 0; i < 8; i++) t64(4'b0010, up_seq[i], 32, 2'b01);
    @(negedge clk); #1 rst_n = 1'b0; #2 rst_n = 1'b1;
    p64(32, 32);

    // Full acceleration profile from the centre.
    for (int i = 0; i < 10; i++) t64(4'b0010, up_seq[i], 32, 2'b01);

    // Centre request wins over tick+up on the same clock.
    drive(1'b0, 4'b0010, 1'b1, 2'b01, 1'b0, 32, 32, 2'b00, 2'b00, 2'b00);

    // Freeze holds position and the hold count.
    t64(4'b0010, 33, 32, 2'b01);
    t64(4'b0010, 34, 32, 2'b01);
    fr64 = 1'b1;
    for (int i = 0; i < 3; i++) t64(4'b0010, 34, 32, 2'b00);
    fr64 = 1'b0;
    t64(4'b0010, 35, 32, 2'b01);
    t64(4'b0010, 36, 32, 2'b01);
    t64(4'b0010, 38, 32, 2'b01);

    // Both buttons reset the step; reversal moves by one.
    t64(4'b0011, 38, 32, 2'b00);
    t64(4'b0010, 39, 32, 2'b01);
    t64(4'b0010, 40, 32, 2'b01);
    t64(4'b0010, 41, 32, 2'b01);
    t64(4'b0010, 42, 32, 2'b01);
    t64(4'b0010, 44, 32, 2'b01);
    t64(4'b0001, 43, 32, 2'b01);
    t64(4'b0010, 44, 32, 2'b01);

    // Controls without ticks are ignored; a 00 tick does not move.
    @(negedge clk); ctl64 = 4'b0010;
    repeat (100) @(negedge clk);
    p64(44, 32);
    t64(4'b0000, 44, 32, 2'b00);

    // Channel independence.
    t64(4'b0100, 44, 31, 2'b10);
    t64(4'b1010, 45, 32, 2'b11);

    // 16-row field: p0 down into the bottom limit, p1 up into the top limit.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 4'b1001, 1'b1, 2'b00, 1'b0, dn16[i], up16[i], 2'b11,
            (i == 4) ? 2'b01 : 2'b00, (i == 4) ? 2'b10 : 2'b00);
    for (int i = 0; i < 2; i++)
      drive(1'b1, 4'b1001, 1'b1, 2'b00, 1'b0, 2, 13, 2'b00, 2'b01, 2'b10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
